// File: rtl/pc_fetch_pkg.sv
// Shared encodings for the instruction fetch controller: FSM states, pcsource codes
// and the branch-offset helper.
package pc_fetch_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_EXEC  = 3'd2,
    ST_HALT  = 3'd3,
    ST_FAULT = 3'd4
  } fetch_state_e;

  localparam logic [1:0] PCS_SEQ = 2'b00;
  localparam logic [1:0] PCS_BR  = 2'b01;
  localparam logic [1:0] PCS_REG = 2'b10;
  localparam logic [1:0] PCS_JMP = 2'b11;

  // Sign-extended 16-bit word offset, scaled to a byte offset.
  function automatic logic [31:0] br_offset(input logic [15:0] imm);
    return {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/pc_fetch_ctrl_npc_calc.sv
// Combinational next-PC selection and legality check (word aligned, inside the IROM).
module npc_calc
  import pc_fetch_pkg::*;
#(
  parameter int ROM_AW = 6
) (
  input  logic [31:0] pc_plus4,
  input  logic [31:0] inst,
  input  logic [1:0]  pcsource,
  input  logic [31:0] ra_data,
  output logic [31:0] npc,
  output logic        npc_legal
);

  logic [5:0] unused_opcode;
  assign unused_opcode = inst[31:26];

  always_comb begin
    npc = pc_plus4;
    case (pcsource)
      PCS_SEQ: npc = pc_plus4;
      PCS_BR:  npc = pc_plus4 + br_offset(inst[15:0]);
      PCS_REG: npc = ra_data;
      PCS_JMP: npc = {pc_plus4[31:28], inst[25:0], 2'b00};
      default: npc = pc_plus4;
    endcase
  end

  assign npc_legal = (npc[1:0] == 2'b00) && (npc[31:ROM_AW+2] == '0);

endmodule

// File: rtl/pc_fetch_ctrl.sv
// Instruction fetch controller: PC register, run/step sequencing, halt/fault
// detection and retired-instruction counter.
module pc_fetch_ctrl
  import pc_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          ROM_AW   = 6
) (
  input  logic              sys_rst_n,
  input  logic              clock_1s,
  input  logic              run_mode,
  input  logic              step_btn,
  input  logic [31:0]       inst,
  input  logic [1:0]        pcsource,
  input  logic [31:0]       ra_data,
  output logic [31:0]       pc,
  output logic [ROM_AW-1:0] addra,
  output logic [31:0]       pc_plus4,
  output logic              inst_valid,
  output logic              halted,
  output logic              fault,
  output logic [15:0]       retired
);

  fetch_state_e state_q;
  logic [31:0]  pc_q;
  logic [15:0]  retired_q;
  logic [15:0]  retired_d;
  logic         step_prev_q;
  logic         inst_valid_q;
  logic         halted_q;
  logic         fault_q;
  logic         step_edge;
  logic [31:0]  npc;
  logic         npc_legal;

  assign pc_plus4  = pc_q + 32'd4;
  assign addra     = pc_q[ROM_AW+1:2];
  assign retired_d = retired_q + 16'd1;
  // The sampler runs in every state, so presses outside IDLE are consumed, not queued.
  assign step_edge = step_btn & ~step_prev_q;

  npc_calc #(.ROM_AW(ROM_AW)) u_npc_calc (
    .pc_plus4  (pc_plus4),
    .inst      (inst),
    .pcsource  (pcsource),
    .ra_data   (ra_data),
    .npc       (npc),
    .npc_legal (npc_legal)
  );

  always_ff @(posedge clock_1s or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q      <= ST_IDLE;
      pc_q         <= RESET_PC;
      retired_q    <= 16'h0000;
      step_prev_q  <= 1'b0;
      inst_valid_q <= 1'b0;
      halted_q     <= 1'b0;
      fault_q      <= 1'b0;
    end else begin
      step_prev_q <= step_btn;
      case (state_q)
        ST_IDLE: begin
          if (run_mode || step_edge) state_q <= ST_FETCH;
        end
        ST_FETCH: begin
          state_q      <= ST_EXEC;
          inst_valid_q <= 1'b1;
        end
        ST_EXEC: begin
          inst_valid_q <= 1'b0;
          // Illegal target wins over self-loop.
          if (!npc_legal) begin
            fault_q <= 1'b1;
            state_q <= ST_FAULT;
          end else if (npc == pc_q) begin
            halted_q  <= 1'b1;
            retired_q <= retired_d;
            state_q   <= ST_HALT;
          end else begin
            pc_q      <= npc;
            retired_q <= retired_d;
            state_q   <= run_mode ? ST_FETCH : ST_IDLE;
          end
        end
        ST_HALT:  state_q <= ST_HALT;
        ST_FAULT: state_q <= ST_FAULT;
        default:  state_q <= ST_IDLE;
      endcase
    end
  end

  assign pc         = pc_q;
  assign retired    = retired_q;
  assign inst_valid = inst_valid_q;
  assign halted     = halted_q;
  assign fault      = fault_q;

endmodule
